// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: rounding modes, fflags layout, special encodings and the
// record carried between the round and pack stages.
package fp32_pkg;

    typedef enum logic [2:0] {
        RmRne = 3'b000,
        RmRtz = 3'b001,
        RmRdn = 3'b010,
        RmRup = 3'b011,
        RmRmm = 3'b100
    } rm_e;

    // Bit positions inside the 5-bit fflags vector {NV, DZ, OF, UF, NX}.
    localparam int unsigned FlagNv = 4;
    localparam int unsigned FlagDz = 3;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagUf = 1;
    localparam int unsigned FlagNx = 0;

    localparam logic [31:0] FP32_CANON_NAN      = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF        = 32'h7F80_0000;
    localparam logic [30:0] FP32_MAX_FINITE_MAG = 31'h7F7F_FFFF;

    // Rounded-but-unpacked value plus the special-case flags it travels with.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        rnd_ovf;
        logic        inexact;
        logic        zero;
        logic        ovf;
        logic        unf;
        logic        nan;
        logic        inf;
        logic        invalid;
        logic [2:0]  rm;
    } rnd_stage_t;

    // On overflow, decide between infinity and the largest finite magnitude.
    // Unassigned encodings behave like RNE.
    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        logic to_inf;
        case (rm)
            RmRtz:   to_inf = 1'b0;
            RmRdn:   to_inf = sign;
            RmRup:   to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase
        return to_inf;
    endfunction

endpackage

// File: rtl/fp32_round_incr.sv
// Rounding-increment decision for one normalized mantissa under a RISC-V rounding mode.
module fp32_round_incr
    import fp32_pkg::*;
(
    input  logic       sign,
    input  logic       mant_lsb,
    input  logic [2:0] grs,
    input  logic [2:0] rm,
    output logic       inc,
    output logic       inexact
);

    logic g;
    logic r;
    logic s;

    assign g = grs[2];
    assign r = grs[1];
    assign s = grs[0];

    // Decide whether to add one ulp; reserved modes fall back to RNE.
    always_comb begin
        inexact = g | r | s;
        inc     = 1'b0;
        case (rm)
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = sign & (g | r | s);
            RmRup:   inc = ~sign & (g | r | s);
            RmRmm:   inc = g;
            default: inc = g & (r | s | mant_lsb);
        endcase
    end

endmodule

// File: rtl/fp32_round_pack.sv
// FP32 round-and-pack: stage 1 rounds the normalized mantissa, stage 2 resolves special
// cases, packs the IEEE-754 word and forms RISC-V fflags. Valid/ready on both sides.
module fp32_round_pack
    import fp32_pkg::*;
#(
    parameter int unsigned FTZ = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [22:0] i_mantissa,
    input  logic [2:0]  i_grs,
    input  logic        i_zero_detect,
    input  logic        i_overflow,
    input  logic        i_underflow,
    input  logic        i_nan,
    input  logic        i_inf,
    input  logic        i_invalid,
    input  logic [2:0]  i_rm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_fflags
);

    logic        s1_valid_q;
    logic        s1_valid_d;
    logic        s2_valid_q;
    logic        s2_valid_d;
    logic        s1_advance;
    logic        accept;

    rnd_stage_t  s1_d;
    rnd_stage_t  s1_q;

    logic        inc;
    logic        inexact;
    logic [23:0] mant_sum;

    logic [31:0] result_d;
    logic [31:0] result_q;
    logic [4:0]  fflags_d;
    logic [4:0]  fflags_q;

    // Stage 1 moves on when stage 2 is empty or being drained this cycle.
    assign s1_advance = s1_valid_q & (~s2_valid_q | i_ready);
    assign o_ready    = ~s1_valid_q | s1_advance;
    assign accept     = i_valid & o_ready;

    assign o_valid  = s2_valid_q;
    assign o_result = result_q;
    assign o_fflags = fflags_q;

    fp32_round_incr u_round_incr (
        .sign     (i_sign),
        .mant_lsb (i_mantissa[0]),
        .grs      (i_grs),
        .rm       (i_rm),
        .inc      (inc),
        .inexact  (inexact)
    );

    // Round the incoming mantissa; a carry out of the fraction bumps the exponent.
    always_comb begin
        mant_sum     = {1'b0, i_mantissa} + {23'd0, inc};
        s1_d         = '0;
        s1_d.sign    = i_sign;
        s1_d.inexact = inexact;
        s1_d.zero    = i_zero_detect;
        s1_d.ovf     = i_overflow;
        s1_d.unf     = i_underflow;
        s1_d.nan     = i_nan;
        s1_d.inf     = i_inf;
        s1_d.invalid = i_invalid;
        s1_d.rm      = i_rm;
        if (mant_sum[23]) begin
            s1_d.exp  = i_exp + 8'd1;
            s1_d.mant = '0;
        end else begin
            s1_d.exp  = i_exp;
            s1_d.mant = mant_sum[22:0];
        end
        s1_d.rnd_ovf = (s1_d.exp == 8'hFF);
    end

    // Pack the rounded value, highest-priority special case first.
    always_comb begin
        result_d         = {s1_q.sign, s1_q.exp, s1_q.mant};
        fflags_d         = '0;
        fflags_d[FlagNx] = s1_q.inexact;
        if (s1_q.nan) begin
            result_d         = FP32_CANON_NAN;
            fflags_d         = '0;
            fflags_d[FlagNv] = s1_q.invalid;
        end else if (s1_q.inf) begin
            result_d = {s1_q.sign, FP32_POS_INF[30:0]};
            fflags_d = '0;
        end else if (s1_q.zero) begin
            result_d = {s1_q.sign, 31'h0};
            fflags_d = '0;
        end else if (s1_q.ovf || s1_q.rnd_ovf) begin
            result_d         = ovf_to_inf(s1_q.rm, s1_q.sign) ? {s1_q.sign, FP32_POS_INF[30:0]}
                                                              : {s1_q.sign, FP32_MAX_FINITE_MAG};
            fflags_d         = '0;
            fflags_d[FlagOf] = 1'b1;
            fflags_d[FlagNx] = 1'b1;
        end else if (s1_q.unf || ((FTZ != 0) && (s1_q.exp == 8'h00))) begin
            // Denormal range is flushed to signed zero.
            result_d         = {s1_q.sign, 31'h0};
            fflags_d         = '0;
            fflags_d[FlagUf] = 1'b1;
            fflags_d[FlagNx] = 1'b1;
        end
    end

    // Stage valid next-state; flush wins over a simultaneous accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (i_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s1_advance) begin
                s1_valid_d = 1'b0;
            end
            if (s1_advance) begin
                s2_valid_d = 1'b1;
            end else if (i_ready) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    // Pipeline valid registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1 data captures only on an accepted transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= '0;
        end else if (accept && !i_flush) begin
            s1_q <= s1_d;
        end
    end

    // Output data changes only when a new result moves in, so it holds under stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= 32'h0;
            fflags_q <= 5'h0;
        end else if (s1_advance && !i_flush) begin
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

endmodule

// File: tb/tb_fp32_round_pack.sv
// Directed bench for fp32_round_pack with a scoreboard of expected {result, fflags}.
module tb_fp32_round_pack;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    // Special-flag bundle {zero, ovf, unf, nan, inf, invalid}.
    localparam logic [5:0] SP_NONE = 6'b000000;
    localparam logic [5:0] SP_ZERO = 6'b100000;
    localparam logic [5:0] SP_OVF  = 6'b010000;
    localparam logic [5:0] SP_UNF  = 6'b001000;
    localparam logic [5:0] SP_NAN  = 6'b000100;
    localparam logic [5:0] SP_INF  = 6'b000010;
    localparam logic [5:0] SP_INV  = 6'b000001;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [22:0] i_mantissa = '0;
    logic [2:0]  i_grs = '0;
    logic        i_zero_detect = 1'b0;
    logic        i_overflow = 1'b0;
    logic        i_underflow = 1'b0;
    logic        i_nan = 1'b0;
    logic        i_inf = 1'b0;
    logic        i_invalid = 1'b0;
    logic [2:0]  i_rm = '0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_fflags;

    fp32_round_pack #(.FTZ(1)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sign        (i_sign),
        .i_exp         (i_exp),
        .i_mantissa    (i_mantissa),
        .i_grs         (i_grs),
        .i_zero_detect (i_zero_detect),
        .i_overflow    (i_overflow),
        .i_underflow   (i_underflow),
        .i_nan         (i_nan),
        .i_inf         (i_inf),
        .i_invalid     (i_invalid),
        .i_rm          (i_rm),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_fflags      (o_fflags)
    );

    always #5 i_clk = ~i_clk;

    logic [36:0] sb_q[$];
    string       tag_q[$];
    logic [36:0] exp_cur;
    string       tag_cur;
    logic        last_acc;
    logic [36:0] hold;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: compare any output leaving the DUT, record any input it takes.
    task automatic tick();
        logic [36:0] e;
        string       t;
        @(negedge i_clk);
        if (o_valid && i_ready) begin
            check("sb_nonempty", 37'(sb_q.size() != 0), 37'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                check(t, {o_result, o_fflags}, e);
            end
        end
        last_acc = i_valid && o_ready && !i_flush;
        if (last_acc) begin
            sb_q.push_back(exp_cur);
            tag_q.push_back(tag_cur);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input string tag, input logic s, input logic [7:0] e,
                         input logic [22:0] m, input logic [2:0] grs, input logic [2:0] rm,
                         input logic [5:0] sp, input logic [31:0] res, input logic [4:0] fl);
        i_sign     = s;
        i_exp      = e;
        i_mantissa = m;
        i_grs      = grs;
        i_rm       = rm;
        {i_zero_detect, i_overflow, i_underflow, i_nan, i_inf, i_invalid} = sp;
        exp_cur    = {res, fl};
        tag_cur    = tag;
        i_valid    = 1'b1;
        check("rm_legal", 37'(i_rm <= 3'd4), 37'd1);
    endtask

    task automatic send(input string tag, input logic s, input logic [7:0] e,
                        input logic [22:0] m, input logic [2:0] grs, input logic [2:0] rm,
                        input logic [5:0] sp, input logic [31:0] res, input logic [4:0] fl);
        logic acc;
        acc = 1'b0;
        drive(tag, s, e, m, grs, rm, sp, res, fl);
        for (int k = 0; k < 20 && !acc; k++) begin
            tick();
            acc = last_acc;
        end
        check({tag, "_accept"}, 37'(acc), 37'd1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            tick();
        end
        check("drain_empty", 37'(sb_q.size()), 37'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", 37'(o_valid), 37'd0);
        check("rst_result", 37'(o_result), 37'd0);
        check("rst_fflags", 37'(o_fflags), 37'd0);
        check("rst_ready", 37'(o_ready), 37'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;

        // Latency: o_valid on the second edge after acceptance
        drive("one", 1'b0, 8'h7F, 23'h0, 3'b000, RNE, SP_NONE, 32'h3F80_0000, 5'h00);
        tick();
        check("lat_accept", 37'(last_acc), 37'd1);
        i_valid = 1'b0;
        check("lat_edge1", 37'(o_valid), 37'd0);
        tick();
        check("lat_edge2", 37'(o_valid), 37'd1);
        drain();

        // Back-to-back directed vectors
        send("rne_tie_odd",  1'b0, 8'h7F, 23'h000001, 3'b100, RNE, SP_NONE, 32'h3F80_0002, 5'h01);
        send("rne_tie_even", 1'b0, 8'h7F, 23'h000000, 3'b100, RNE, SP_NONE, 32'h3F80_0000, 5'h01);
        send("carry_rne",    1'b0, 8'h7F, 23'h7FFFFF, 3'b110, RNE, SP_NONE, 32'h4000_0000, 5'h01);
        send("carry_rtz",    1'b0, 8'h7F, 23'h7FFFFF, 3'b110, RTZ, SP_NONE, 32'h3FFF_FFFF, 5'h01);
        send("ovf_rup_neg",  1'b1, 8'hFE, 23'h0, 3'b000, RUP, SP_OVF, 32'hFF7F_FFFF, 5'h05);
        send("ovf_rdn_neg",  1'b1, 8'hFE, 23'h0, 3'b000, RDN, SP_OVF, 32'hFF80_0000, 5'h05);
        send("rnd_ovf_rne",  1'b0, 8'hFE, 23'h7FFFFF, 3'b100, RNE, SP_NONE, 32'h7F80_0000, 5'h05);
        send("ovf_rtz_pos",  1'b0, 8'hFE, 23'h0, 3'b000, RTZ, SP_OVF, 32'h7F7F_FFFF, 5'h05);
        send("nan_inv",      1'b0, 8'h00, 23'h0, 3'b000, RNE, SP_NAN | SP_INV | SP_OVF,
             32'h7FC0_0000, 5'h10);
        send("nan_quiet",    1'b1, 8'h00, 23'h0, 3'b000, RNE, SP_NAN, 32'h7FC0_0000, 5'h00);
        send("unf_neg",      1'b1, 8'h01, 23'h0, 3'b000, RNE, SP_UNF, 32'h8000_0000, 5'h03);
        send("ftz_exp0",     1'b0, 8'h00, 23'h000005, 3'b000, RNE, SP_NONE, 32'h0000_0000, 5'h03);
        send("rup_pos",      1'b0, 8'h80, 23'h0, 3'b001, RUP, SP_NONE, 32'h4000_0001, 5'h01);
        send("rdn_pos",      1'b0, 8'h80, 23'h0, 3'b111, RDN, SP_NONE, 32'h4000_0000, 5'h01);
        send("rdn_neg",      1'b1, 8'h80, 23'h000005, 3'b010, RDN, SP_NONE, 32'hC000_0006, 5'h01);
        send("rmm_tie",      1'b0, 8'h7F, 23'h000002, 3'b100, RMM, SP_NONE, 32'h3F80_0003, 5'h01);
        send("zero_neg",     1'b1, 8'h00, 23'h0, 3'b000, RNE, SP_ZERO, 32'h8000_0000, 5'h00);
        send("inf_pos",      1'b0, 8'h00, 23'h0, 3'b000, RNE, SP_INF, 32'h7F80_0000, 5'h00);
        drain();

        // Back-pressure: i_ready low for three cycles while streaming four items
        i_ready = 1'b0;
        drive("st1", 1'b0, 8'h80, 23'h400000, 3'b000, RNE, SP_NONE, 32'h4040_0000, 5'h00);
        tick();
        check("st1_acc", 37'(last_acc), 37'd1);
        drive("st2", 1'b0, 8'h81, 23'h000000, 3'b000, RNE, SP_NONE, 32'h4080_0000, 5'h00);
        tick();
        check("st2_acc", 37'(last_acc), 37'd1);
        drive("st3", 1'b0, 8'h81, 23'h200000, 3'b000, RNE, SP_NONE, 32'h40A0_0000, 5'h00);
        check("full_ready", 37'(o_ready), 37'd0);
        check("full_valid", 37'(o_valid), 37'd1);
        hold = {o_result, o_fflags};
        tick();
        check("st3_blocked", 37'(last_acc), 37'd0);
        check("stall_hold", {o_result, o_fflags}, hold);
        i_ready = 1'b1;
        send("st3", 1'b0, 8'h81, 23'h200000, 3'b000, RNE, SP_NONE, 32'h40A0_0000, 5'h00);
        send("st4", 1'b1, 8'h82, 23'h000000, 3'b000, RNE, SP_NONE, 32'hC100_0000, 5'h00);
        drain();

        // Flush with two in flight
        i_ready = 1'b0;
        send("fl1", 1'b0, 8'h7F, 23'h0, 3'b000, RNE, SP_NONE, 32'h3F80_0000, 5'h00);
        send("fl2", 1'b0, 8'h80, 23'h0, 3'b000, RNE, SP_NONE, 32'h4000_0000, 5'h00);
        check("pre_flush_valid", 37'(o_valid), 37'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        sb_q.delete();
        tag_q.delete();
        check("flush_valid", 37'(o_valid), 37'd0);
        check("flush_ready", 37'(o_ready), 37'd1);
        tick();
        check("flush_s1_clear", 37'(o_valid), 37'd0);

        // Asynchronous reset mid-stream
        send("rs1", 1'b1, 8'h80, 23'h0, 3'b000, RNE, SP_NONE, 32'hC000_0000, 5'h00);
        send("rs2", 1'b0, 8'h80, 23'h0, 3'b000, RNE, SP_NONE, 32'h4000_0000, 5'h00);
        check("pre_rst_valid", 37'(o_valid), 37'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 37'(o_valid), 37'd0);
        check("mid_rst_result", 37'(o_result), 37'd0);
        check("mid_rst_fflags", 37'(o_fflags), 37'd0);
        sb_q.delete();
        tag_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        send("post_rst", 1'b0, 8'h7F, 23'h000001, 3'b100, RNE, SP_NONE, 32'h3F80_0002, 5'h01);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_round_pack.md
Name: fp32_round_pack

Overview:
- Stage directly downstream of the FP32 add/sub normalization stage.
- Consumes the normalized exponent, mantissa, guard/round/sticky bits and the zero/overflow/underflow indications, plus upstream special-case flags.
- Applies the RISC-V rounding mode, handles mantissa carry into the exponent, packs the IEEE-754 single result, and produces RISC-V fflags.
- Two-stage pipeline with valid/ready handshake on both sides and a synchronous flush.

Parameters:
- FTZ, 1, flush results with biased exponent 0 (denormal range) to signed zero; only value 1 is supported.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_flush  input  1  synchronous pipeline clear
- i_valid  input  1  upstream data valid
- o_ready  output  1  this block can accept
- i_sign  input  1  result sign, already IEEE-resolved upstream (including zero sign)
- i_exp  input  8  normalized biased exponent
- i_mantissa  input  23  normalized fraction, hidden bit excluded
- i_grs  input  3  guard, round, sticky
- i_zero_detect  input  1  exact zero result
- i_overflow  input  1  exponent above 254 before rounding
- i_underflow  input  1  exponent negative before rounding
- i_nan  input  1  result is NaN
- i_inf  input  1  result is exact infinity (from an infinite operand)
- i_invalid  input  1  invalid-operation condition
- i_rm  input  3  RISC-V rounding mode
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts
- o_result  output  32  packed FP32
- o_fflags  output  5  {NV, DZ, OF, UF, NX}

Behaviour:
- Reset: stage valids = 0, o_valid = 0, o_result = 32'h0, o_fflags = 5'h0. Reset may be asserted mid-operation; in-flight data is discarded.
- Handshake:
  - Transfer occurs when valid & ready are both high.
  - Stage N advances when its successor is empty or is advancing.
  - o_ready = ~s1_valid | s1_advance; it is combinational from i_ready.
  - o_result and o_fflags hold stable while o_valid=1 and i_ready=0.
- Latency: 2 cycles from input acceptance to o_valid with no stall. Throughput is 1 per cycle.
- i_flush: both stage valids clear on the next edge. Flush has priority over a simultaneous accept. o_ready is don't-care during flush.
- Stage 1 (round):
  - Increment decision by rounding mode:
    - RNE (000): G & (R | S | M[0])
    - RTZ (001): 0
    - RDN (010): sign & (G|R|S)
    - RUP (011): ~sign & (G|R|S)
    - RMM (100): G
  - rm 101–111 are treated as RNE; the bench asserts they never occur.
  - inexact = G|R|S.
  - Form {1'b0, mant} + inc as a 24-bit sum. On carry-out, mantissa = 0 and exp + 1.
  - Rounded exp == 255 sets round_overflow.
- Stage 2 (pack), priority order:
  1. nan: 32'h7FC00000; NV = i_invalid; all other flags 0.
  2. inf: {sign, 8'hFF, 23'h0}; flags 0.
  3. zero_detect: {sign, 31'h0}; flags 0.
  4. i_overflow or round_overflow: OF = 1, NX = 1.
     - Result is ±inf for RNE/RMM, for RUP when positive, and for RDN when negative.
     - Otherwise the result is ±max finite, {sign, 8'hFE, 23'h7FFFFF}.
  5. i_underflow, or rounded exp == 0: result is {sign, 31'h0}; UF = 1, NX = 1.
  6. Normal: {sign, exp, mant}; NX = inexact.
- DZ is always 0.

Decomposition:
- Shared package fp32_pkg:
  - rounding-mode enum (RNE, RTZ, RDN, RUP, RMM)
  - fflags bit index constants
  - FP32_CANON_NAN, FP32_POS_INF, FP32_MAX_FINITE_MAG
- Sub-module fp32_round_incr (combinational):
  - inputs: sign, mantissa LSB, grs, rm
  - outputs: inc, inexact
  - instantiated in stage 1.

Test Plan:
- Exact 1.0: sign=0, exp=0x7F, mant=0, grs=000, RNE → o_result 0x3F800000, fflags 0x00, o_valid exactly 2 cycles after accept.
- RNE tie-to-even:
  - mant=0x000001, grs=100 → 0x3F800002, fflags 0x01.
  - mant=0x000000, grs=100 → 0x3F800000, fflags 0x01.
- Mantissa carry: exp=0x7F, mant=0x7FFFFF, grs=110, RNE → 0x40000000, fflags 0x01. Same input with RTZ → 0x3FFFFFFF, fflags 0x01.
- Overflow by rounding mode: i_overflow=1, sign=1:
  - RUP → 0xFF7FFFFF, fflags 0x05.
  - RDN → 0xFF800000, fflags 0x05.
  - Also: exp=0xFE, mant=0x7FFFFF, grs=100, RNE → 0x7F800000, fflags 0x05.
- Specials and flags:
  - i_nan=1, i_invalid=1 → 0x7FC00000, fflags 0x10.
  - i_underflow=1, sign=1 → 0x80000000, fflags 0x03.
- Handshake and reset:
  - Stream 4 transactions while holding i_ready=0 for 3 cycles: output holds stable, o_ready drops once both stages are full, and no transaction is lost or duplicated.
  - i_flush with 2 in flight → o_valid=0 next cycle.
  - Assert i_rst_n=0 mid-stream → outputs zero immediately.
